// File: rtl/led_blink_bank.sv
// Multi-channel LED pattern generator.
// A shared prescaler produces a registered one-cycle tick; each channel runs
// OFF / ON / BLINK / ONESHOT from that tick with its own half-period.
//
// state (channel mode) | meaning
// ---------------------+---------------------------------------------------
// MODE_OFF     (0)     | LED dark, counter parked at 0
// MODE_ON      (1)     | LED lit, counter parked at 0
// MODE_BLINK   (2)     | LED toggles every eff_half ticks, 50% duty
// MODE_ONESHOT (3)     | LED lit for eff_half ticks, then falls back to OFF
module led_blink_bank #(
   parameter int CLK_HZ       = 25_000_000,
   parameter int TICK_HZ      = 1_000,
   parameter int N_CH         = 4,
   parameter int HALF_W       = 16,
   parameter int DEFAULT_HALF = 500,
   localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic              i_Cfg_Wr,
   input  logic [CH_W-1:0]   i_Cfg_Ch,
   input  logic [1:0]        i_Cfg_Mode,
   input  logic [HALF_W-1:0] i_Cfg_Half,
   input  logic              i_Sync,
   output logic              o_Tick,
   output logic [N_CH-1:0]   o_LED,
   output logic [N_CH-1:0]   o_Busy
);

   localparam int PRESCALE = CLK_HZ / TICK_HZ;
   localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [HALF_W-1:0] HALF_RST = HALF_W'(DEFAULT_HALF);

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_ON      = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_ONESHOT = 2'd3;

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic              tick_q, tick_d;

   logic [1:0]        mode_q [N_CH];
   logic [1:0]        mode_d [N_CH];
   logic [HALF_W-1:0] half_q [N_CH];
   logic [HALF_W-1:0] half_d [N_CH];
   logic [HALF_W-1:0] cnt_q  [N_CH];
   logic [HALF_W-1:0] cnt_d  [N_CH];
   logic [N_CH-1:0]   led_q, led_d;
   logic [N_CH-1:0]   busy_q, busy_d;

   logic [HALF_W-1:0] eff_half [N_CH];
   logic [N_CH-1:0]   at_end;

   // Prescaler next state; sync restarts the tick phase and kills a pending tick.
   always_comb begin
      pre_d  = pre_q;
      tick_d = 1'b0;
      if (i_Sync) begin
         pre_d  = '0;
         tick_d = 1'b0;
      end else begin
         pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
         tick_d = (pre_q == PRE_LAST);
      end
   end

   // Prescaler and tick registers.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
      end
   end

   // Effective half-period (0 behaves as 1) and end-of-half detect per channel.
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         eff_half[c] = (half_q[c] == '0) ? HALF_W'(1) : half_q[c];
         at_end[c]   = (cnt_q[c] == eff_half[c] - HALF_W'(1));
      end
   end

   // Channel next state: addressed write beats sync, sync beats tick.
   always_comb begin
      led_d  = led_q;
      busy_d = busy_q;
      for (int c = 0; c < N_CH; c++) begin
         mode_d[c] = mode_q[c];
         half_d[c] = half_q[c];
         cnt_d[c]  = cnt_q[c];
         if (i_Cfg_Wr && (int'(i_Cfg_Ch) == c)) begin
            mode_d[c] = i_Cfg_Mode;
            half_d[c] = i_Cfg_Half;
            cnt_d[c]  = '0;
            led_d[c]  = (i_Cfg_Mode == MODE_ON) || (i_Cfg_Mode == MODE_ONESHOT);
            busy_d[c] = (i_Cfg_Mode == MODE_ONESHOT);
         end else begin
            case (mode_q[c])
               MODE_OFF: begin
                  cnt_d[c]  = '0;
                  led_d[c]  = 1'b0;
                  busy_d[c] = 1'b0;
               end
               MODE_ON: begin
                  cnt_d[c]  = '0;
                  led_d[c]  = 1'b1;
                  busy_d[c] = 1'b0;
               end
               MODE_BLINK: begin
                  busy_d[c] = 1'b0;
                  if (i_Sync) begin
                     cnt_d[c] = '0;
                     led_d[c] = 1'b0;
                  end else if (tick_q) begin
                     if (at_end[c]) begin
                        cnt_d[c] = '0;
                        led_d[c] = ~led_q[c];
                     end else begin
                        cnt_d[c] = cnt_q[c] + 1'b1;
                     end
                  end
               end
               default: begin
                  if (tick_q) begin
                     if (at_end[c]) begin
                        cnt_d[c]  = '0;
                        led_d[c]  = 1'b0;
                        busy_d[c] = 1'b0;
                        mode_d[c] = MODE_OFF;
                     end else begin
                        cnt_d[c] = cnt_q[c] + 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   // Channel registers; every channel comes out of reset blinking at the default rate.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         for (int c = 0; c < N_CH; c++) begin
            mode_q[c] <= MODE_BLINK;
            half_q[c] <= HALF_RST;
            cnt_q[c]  <= '0;
         end
         led_q  <= '0;
         busy_q <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            mode_q[c] <= mode_d[c];
            half_q[c] <= half_d[c];
            cnt_q[c]  <= cnt_d[c];
         end
         led_q  <= led_d;
         busy_q <= busy_d;
      end
   end

   assign o_Tick = tick_q;
   assign o_LED  = led_q;
   assign o_Busy = busy_q;

endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank: directed scenarios plus random traffic, every
// cycle compared against a tick-count model of the LED patterns.
module tb_led_blink_bank;

   localparam int N  = 3;
   localparam int HW = 8;
   localparam int P  = 10;
   localparam int DH = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr;
   logic [1:0]    ch;
   logic [1:0]    mode;
   logic [HW-1:0] half;
   logic          sync;
   logic          tick;
   logic [N-1:0]  led;
   logic [N-1:0]  busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   led_blink_bank #(
      .CLK_HZ(100), .TICK_HZ(10), .N_CH(N), .HALF_W(HW), .DEFAULT_HALF(DH)
   ) dut (
      .i_Clk(clk), .i_Reset(rst), .i_Cfg_Wr(wr), .i_Cfg_Ch(ch),
      .i_Cfg_Mode(mode), .i_Cfg_Half(half), .i_Sync(sync),
      .o_Tick(tick), .o_LED(led), .o_Busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: ticks arrive every P cycles since the last reset/sync; each channel
   // keeps the number of ticks since it was (re)started and derives its LED.
   bit mvalid = 0;
   int cyc = 0;
   int since;
   bit m_tick;
   int m_mode [N];
   int m_half [N];
   int m_n    [N];

   function automatic int eff(input int h);
      return (h == 0) ? 1 : h;
   endfunction

   function automatic bit exp_led(input int c);
      case (m_mode[c])
         0: return 1'b0;
         1: return 1'b1;
         2: return 1'((m_n[c] / eff(m_half[c])) % 2);
         default: return 1'b1;
      endcase
   endfunction

   always @(posedge clk) begin
      bit t;
      t = m_tick;
      if (rst) begin
         mvalid = 1;
         cyc    = 0;
         since  = 0;
         m_tick = 0;
         for (int c = 0; c < N; c++) begin
            m_mode[c] = 2; m_half[c] = DH; m_n[c] = 0;
         end
      end else if (mvalid) begin
         cyc++;
         if (sync) begin
            since = 0; m_tick = 0;
         end else begin
            since++; m_tick = (since % P == 0);
         end
         for (int c = 0; c < N; c++) begin
            if (wr && int'(ch) == c) begin
               m_mode[c] = int'(mode); m_half[c] = int'(half); m_n[c] = 0;
            end else if (sync && m_mode[c] == 2) begin
               m_n[c] = 0;
            end else if (t && (m_mode[c] == 2 || m_mode[c] == 3)) begin
               m_n[c]++;
               if (m_mode[c] == 3 && m_n[c] >= eff(m_half[c])) begin
                  m_mode[c] = 0; m_n[c] = 0;
               end
            end
         end
      end
      #1;
      if (mvalid) begin
         chk("tick", 32'(tick), 32'(m_tick));
         for (int c = 0; c < N; c++) begin
            chk($sformatf("led%0d", c), 32'(led[c]), 32'(exp_led(c)));
            chk($sformatf("busy%0d", c), 32'(busy[c]), 32'(m_mode[c] == 3));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int k);
      int g;
      g = 0;
      while (cyc < k && g < 5000) begin
         @(negedge clk);
         g++;
      end
      chk("wait_cyc", 32'(cyc >= k), 32'd1);
   endtask

   task automatic wait_tick();
      for (int g = 0; g < 30 && tick !== 1'b1; g++) @(negedge clk);
      chk("tick_wait", 32'(tick), 32'd1);
   endtask

   task automatic write(input int c, input int m, input int h);
      wr = 1'b1; ch = 2'(c); mode = 2'(m); half = HW'(h);
      @(negedge clk);
      wr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr = 1'b0; ch = '0; mode = '0; half = '0; sync = 1'b0;
      cycles(3);
      rst = 1'b0;

      // Power-up blink timing.
      wait_cyc(9);  chk("t1_tick9", 32'(tick), 32'd0);
      wait_cyc(10); chk("t1_tick10", 32'(tick), 32'd1);
      wait_cyc(30); chk("t1_led30", 32'(led), 32'd0);
      wait_cyc(31); chk("t1_led31", 32'(led), 32'd7);
      wait_cyc(61); chk("t1_led61", 32'(led), 32'd0);
      wait_cyc(200);

      // ON then OFF on ch1.
      write(1, 1, 3); chk("t2_on", 32'(led[1]), 32'd1);
      cycles(25);
      write(1, 0, 3); chk("t2_off", 32'(led[1]), 32'd0);

      // ONESHOT on ch2, four ticks long.
      write(2, 3, 4);
      chk("t3_led", 32'(led[2]), 32'd1);
      chk("t3_busy", 32'(busy[2]), 32'd1);
      for (int k = 0; k < 3; k++) begin
         wait_tick(); @(negedge clk);
      end
      chk("t3_busy3", 32'(busy[2]), 32'd1);
      wait_tick(); @(negedge clk);
      chk("t3_busy4", 32'(busy[2]), 32'd0);
      chk("t3_led4", 32'(led[2]), 32'd0);
      cycles(100);
      chk("t3_stay", 32'(busy[2]), 32'd0);

      // BLINK half=0 written on a tick cycle, then an out-of-range write.
      wait_tick();
      write(0, 2, 0); chk("t4_led0", 32'(led[0]), 32'd0);
      wait_tick(); @(negedge clk); chk("t4_tog1", 32'(led[0]), 32'd1);
      wait_tick(); @(negedge clk); chk("t4_tog2", 32'(led[0]), 32'd0);
      write(3, 1, 5);
      cycles(30);

      // Sync two blinking channels at different phases.
      write(0, 2, 3);
      cycles(7);
      write(1, 2, 3);
      cycles(13);
      sync = 1'b1; @(negedge clk); sync = 1'b0;
      chk("t5_sync", 32'(led[1:0]), 32'd0);
      cycles(60);

      // Reset in the middle of a oneshot.
      write(2, 3, 8);
      write(1, 1, 3);
      cycles(5);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      chk("t6_led", 32'(led), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      wait_cyc(10); chk("t6_tick10", 32'(tick), 32'd1);
      wait_cyc(31); chk("t6_led31", 32'(led), 32'd7);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         wr   = ($urandom % 12 == 0);
         ch   = 2'($urandom % 4);
         mode = 2'($urandom % 4);
         half = HW'($urandom % 6);
         sync = ($urandom % 64 == 0);
         rst  = ($urandom % 800 == 0);
         @(negedge clk);
      end
      rst = 1'b0; wr = 1'b0; sync = 1'b0;
      cycles(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
